// File: rtl/shared_adder_sequencer.sv
// Two-requester add/subtract sequencer that time-shares one external 4-bit adder,
// walking the operands one nibble per cycle from the least significant end.
module shared_adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             ack0,
  output logic             ack1,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             carry;
  logic             last_grant;

  logic             grant_any;
  logic             grant_id;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;

  // Round-robin: on a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    grant_any = req0 | req1;
    if (req0 && req1) grant_id = ~last_grant;
    else              grant_id = req1;
  end

  // Acceptance happens at the edge closing this IDLE cycle, so ack is a decode of
  // the current state and requests; rst_n gating keeps it quiet during reset.
  assign ack0 = rst_n && (state == IDLE) && grant_any && !grant_id;
  assign ack1 = rst_n && (state == IDLE) && grant_any &&  grant_id;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    nib_a = op_a[{idx, 2'b00} +: 4];
    nib_b = op_sub ? ~op_b[{idx, 2'b00} +: 4] : op_b[{idx, 2'b00} +: 4];
  end

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == ADD) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = (idx == '0) ? op_sub : carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      result     <= '0;
      cout       <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= ADD;
            idx        <= '0;
            last_grant <= grant_id;
            done_id    <= grant_id;
            op_a       <= grant_id ? a1   : a0;
            op_b       <= grant_id ? b1   : b0;
            op_sub     <= grant_id ? sub1 : sub0;
          end
        end
        ADD: begin
          result[{idx, 2'b00} +: 4] <= add_sum;
          carry                     <= add_cout;
          if (idx == LAST_IDX) begin
            cout  <= add_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sequencer.sv
// Randomized self-checking bench for shared_adder_sequencer (WIDTH=16) with a
// behavioural model of the arithmetic, the nibble walk and the arbitration.
module tb_shared_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        sub0 = 1'b0, sub1 = 1'b0;
  logic        ack0, ack1;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        done, done_id, cout, busy;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit last_model = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The external shared 4-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  shared_adder_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sub0(sub0), .sub1(sub1),
    .ack0(ack0), .ack1(ack1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .done(done), .done_id(done_id),
    .result(result), .cout(cout), .busy(busy)
  );

  function automatic logic [15:0] ref_res(input logic [15:0] a, input logic [15:0] b, input bit s);
    ref_res = s ? (a - b) : (a + b);
  endfunction

  function automatic logic ref_cout(input logic [15:0] a, input logic [15:0] b, input bit s);
    int sum;
    sum = int'(a) + int'(b);
    ref_cout = s ? (a >= b) : (sum > 65535);
  endfunction

  // Carry entering nibble k = carry out of the lower 4k bits of a + b' + s.
  function automatic logic [3:0] ref_cins(input logic [15:0] a, input logic [15:0] b, input bit s);
    int bx, mask, part;
    bx = s ? int'(~b) : int'(b);
    for (int k = 0; k < 4; k++) begin
      mask = (1 << (4 * k)) - 1;
      part = (int'(a) & mask) + (bx & mask) + int'(s);
      ref_cins[k] = part[4 * k];
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_model = 1'b1;
  endtask

  // Drives one single-requester operation and records what the DUT shows.
  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input bit s,
                       output bit ok, output int lat, output logic [15:0] res, output logic co,
                       output logic did, output logic [15:0] aseq, output logic [15:0] bseq,
                       output logic [3:0] cseq);
    int n, ack_c;
    ok = 1'b1; lat = -1; res = 'x; co = 1'bx; did = 1'bx; aseq = 'x; bseq = 'x; cseq = 'x;
    @(negedge clk);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
    #1;
    n = 0;
    while (!(id ? ack1 : ack0) && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) begin ok = 1'b0; req0 = 1'b0; req1 = 1'b0; return; end
    ack_c = cyc;
    last_model = id;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
      aseq[4*k +: 4] = add_a;
      bseq[4*k +: 4] = add_b;
      cseq[k]        = add_cin;
    end
    n = 0;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) begin ok = 1'b0; return; end
    lat = cyc - ack_c; res = result; co = cout; did = done_id;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); end
    total++; if (done !== 1'b0 || done_id !== 1'b0) begin bad++; $display("FAIL reset_done: got %b%b want 00", done, done_id); end
    total++; if (result !== 16'h0 || cout !== 1'b0) begin bad++; $display("FAIL reset_result: got %h/%b want 0000/0", result, cout); end
    total++; if ({add_a, add_b, add_cin} !== 9'h0) begin bad++; $display("FAIL reset_adder: got %h want 000", {add_a, add_b, add_cin}); end
    req0 = 1'b0; req1 = 1'b0;
    apply_reset();
  endtask

  task automatic test_carry();
    bit ok; int lat; logic [15:0] res, as, bs; logic co, did; logic [3:0] cs;
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, ok, lat, res, co, did, as, bs, cs);
    total++; if (!ok || lat !== 5) begin bad++; $display("FAIL carry_latency: got %0d want 5", lat); end
    total++; if (res !== 16'h0000 || co !== 1'b1) begin bad++; $display("FAIL carry_result: got %h/%b want 0000/1", res, co); end
    total++; if (did !== 1'b0) begin bad++; $display("FAIL carry_id: got %b want 0", did); end
  endtask

  task automatic test_sub();
    bit ok; int lat; logic [15:0] res, as, bs; logic co, did; logic [3:0] cs;
    issue(1'b1, 16'h0005, 16'h0007, 1'b1, ok, lat, res, co, did, as, bs, cs);
    total++; if (!ok || res !== 16'hFFFE || co !== 1'b0) begin bad++; $display("FAIL sub_result: got %h/%b want fffe/0", res, co); end
    total++; if (did !== 1'b1) begin bad++; $display("FAIL sub_id: got %b want 1", did); end
    total++; if (cs !== 4'b0001) begin bad++; $display("FAIL sub_cin_seq: got %b want 0001", cs); end
    total++; if (bs !== 16'hFFF8) begin bad++; $display("FAIL sub_b_seq: got %h want fff8", bs); end
  endtask

  task automatic test_nibbles();
    bit ok; int lat; logic [15:0] res, as, bs; logic co, did; logic [3:0] cs;
    issue(1'b0, 16'h1234, 16'h4321, 1'b0, ok, lat, res, co, did, as, bs, cs);
    total++; if (!ok || as !== 16'h1234) begin bad++; $display("FAIL nib_a_seq: got %h want 1234", as); end
    total++; if (bs !== 16'h4321) begin bad++; $display("FAIL nib_b_seq: got %h want 4321", bs); end
    total++; if (res !== 16'h5555 || co !== 1'b0) begin bad++; $display("FAIL nib_result: got %h/%b want 5555/0", res, co); end
  endtask

  task automatic test_hold();
    logic [15:0] r; logic c, d;
    r = ref_res(16'h1234, 16'h4321, 1'b0); c = 1'b0; d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (result !== r || cout !== c || done_id !== d || done !== 1'b0 || busy !== 1'b0 ||
          {add_a, add_b, add_cin} !== 9'h0) begin
        bad++;
        $display("FAIL hold_%0d: got %h/%b/%b done=%b busy=%b add=%h want %h/%b/%b idle", i,
                 result, cout, done_id, done, busy, {add_a, add_b, add_cin}, r, c, d);
      end
    end
  endtask

  task automatic test_tie();
    int n, c, d;
    bit exp;
    @(negedge clk);
    rst_n = 1'b0;
    a0 = 16'h1111; b0 = 16'h0F0F; sub0 = 1'b0;
    a1 = 16'h0100; b1 = 16'h0200; sub1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; last_model = 1'b1;
    #1;
    exp = ~last_model;
    total++; if ({ack1, ack0} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_first: got ack1/ack0=%b want winner %0d", {ack1, ack0}, exp); end
    c = cyc; last_model = exp;
    @(negedge clk); req0 = 1'b0; #1;
    n = 0;
    while (!done && n < 30) begin
      total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL tie_early_ack1: got 1 want 0 at cycle %0d", cyc); end
      @(negedge clk); #1; n++;
    end
    d = cyc;
    total++; if (d - c !== 5 || done_id !== 1'b0 || result !== ref_res(16'h1111, 16'h0F0F, 1'b0)) begin
      bad++; $display("FAIL tie_op0: got lat=%0d id=%b res=%h want 5/0/%h", d - c, done_id, result, ref_res(16'h1111, 16'h0F0F, 1'b0));
    end
    @(negedge clk); #1;
    total++; if (ack1 !== 1'b1 || cyc !== d + 1) begin bad++; $display("FAIL tie_second_ack: got %b want 1 after done", ack1); end
    last_model = 1'b1;
    @(negedge clk); req1 = 1'b0; #1;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    total++; if (done_id !== 1'b1 || result !== 16'hFF00 || cout !== 1'b0) begin
      bad++; $display("FAIL tie_op1: got id=%b res=%h co=%b want 1/ff00/0", done_id, result, cout);
    end
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; #1;
    exp = ~last_model;
    total++; if ({ack1, ack0} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_third: got ack1/ack0=%b want winner %0d", {ack1, ack0}, exp); end
    last_model = exp;
    @(negedge clk); req0 = 1'b0; req1 = 1'b0; #1;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    total++; if (done_id !== exp) begin bad++; $display("FAIL tie_third_id: got %b want %b", done_id, exp); end
  endtask

  task automatic test_reset_mid();
    int n, c, seen_done;
    @(negedge clk);
    req1 = 1'b1; a1 = 16'h1234; b1 = 16'h1111; sub1 = 1'b0; #1;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL rmid_ack: got %b want 1", ack1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    seen_done = 0;
    total++; if (busy !== 1'b0 || result !== 16'h0 || done_id !== 1'b0 || cout !== 1'b0) begin
      bad++; $display("FAIL rmid_clear: got busy=%b res=%h id=%b co=%b want 0/0000/0/0", busy, result, done_id, cout);
    end
    total++; if (ack1 !== 1'b0 || add_a !== 4'h0) begin bad++; $display("FAIL rmid_quiet: got ack1=%b add_a=%h want 0/0", ack1, add_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (done) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d done cycles want 0", seen_done); end
    @(negedge clk); rst_n = 1'b1; last_model = 1'b1; #1;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL rmid_reack: got %b want 1", ack1); end
    c = cyc;
    @(negedge clk); req1 = 1'b0; #1;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    total++; if (cyc - c !== 5 || result !== 16'h2345 || cout !== 1'b0 || done_id !== 1'b1) begin
      bad++; $display("FAIL rmid_complete: got lat=%0d res=%h co=%b id=%b want 5/2345/0/1", cyc - c, result, cout, done_id);
    end
  endtask

  task automatic test_busy_ignore();
    int n, early;
    logic [15:0] x, y;
    x = 16'($urandom); y = 16'($urandom);
    @(negedge clk);
    req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; sub0 = 1'b0; #1;
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL busy_ack0: got %b want 1", ack0); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; a1 = x; b1 = y; sub1 = 1'b1; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_flag: got %b want 1", busy); end
    n = 0; early = 0;
    while (!done && n < 30) begin
      if (ack1) early++;
      @(negedge clk); #1; n++;
    end
    if (ack1) early++;
    total++; if (early !== 0 || result !== 16'h0100) begin bad++; $display("FAIL busy_no_ack1: got %0d early acks res=%h want 0/0100", early, result); end
    @(negedge clk); #1;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL busy_ack1_after_done: got %b want 1", ack1); end
    last_model = 1'b1;
    @(negedge clk); req1 = 1'b0; #1;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    total++; if (result !== ref_res(x, y, 1'b1) || cout !== ref_cout(x, y, 1'b1) || done_id !== 1'b1) begin
      bad++; $display("FAIL busy_op1: got %h/%b/%b want %h/%b/1", result, cout, done_id, ref_res(x, y, 1'b1), ref_cout(x, y, 1'b1));
    end
  endtask

  task automatic test_random();
    bit ok, id, s; int lat; logic [15:0] a, b, res, as, bs; logic co, did; logic [3:0] cs;
    for (int i = 0; i < 30; i++) begin
      id = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      a = 16'($urandom); b = 16'($urandom);
      if (i % 7 == 0) b = a;
      issue(id, a, b, s, ok, lat, res, co, did, as, bs, cs);
      total++;
      if (!ok || lat !== 5 || res !== ref_res(a, b, s) || co !== ref_cout(a, b, s) || did !== id) begin
        bad++; $display("FAIL rand_%0d_op: got ok=%b lat=%0d %h/%b/%b want 5 %h/%b/%b (a=%h b=%h s=%b)",
                        i, ok, lat, res, co, did, ref_res(a, b, s), ref_cout(a, b, s), id, a, b, s);
      end
      total++;
      if (as !== a || bs !== (s ? ~b : b) || cs !== ref_cins(a, b, s)) begin
        bad++; $display("FAIL rand_%0d_walk: got a=%h b=%h cin=%b want %h/%h/%b",
                        i, as, bs, cs, a, s ? ~b : b, ref_cins(a, b, s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_nibbles();
    test_hold();
    test_tie();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
